// File: rtl/vga_grid_controller.sv
// VGA timing generator with registered outputs and an optional grid/cursor overlay.
// Define VGA_GRID_OVERLAY_EN to build the overlay; otherwise host pixels pass straight through.
module vga_grid_controller #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACT    = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACT    = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned COLOR_W  = 10,
    parameter int unsigned GRID_N   = 8,
    parameter int unsigned CELL_W   = 60,
    parameter int unsigned LINE_W   = 2,
    parameter int unsigned GRID_X0  = 155,
    parameter int unsigned GRID_Y0  = 46,
    parameter int unsigned REQ_LEAD = 2
) (
    input  logic                      iCLK,
    input  logic                      iRST_N,
    input  logic [COLOR_W-1:0]        iRed,
    input  logic [COLOR_W-1:0]        iGreen,
    input  logic [COLOR_W-1:0]        iBlue,
    input  logic [$clog2(GRID_N)-1:0] iCur_X,
    input  logic [$clog2(GRID_N)-1:0] iCur_Y,
    output logic                      oRequest,
    output logic [COLOR_W-1:0]        oVGA_R,
    output logic [COLOR_W-1:0]        oVGA_G,
    output logic [COLOR_W-1:0]        oVGA_B,
    output logic                      oVGA_H_SYNC,
    output logic                      oVGA_V_SYNC,
    output logic                      oVGA_SYNC,
    output logic                      oVGA_BLANK,
    output logic [12:0]               oH_Cont,
    output logic [12:0]               oV_Cont,
    output logic                      oFrame_Start
);
    localparam int unsigned CNT_W = 13;
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_SYNC + H_BACK + H_ACT + H_FRONT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_SYNC + V_BACK + V_ACT + V_FRONT - 1);
    localparam logic [CNT_W-1:0] X_START = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] X_END   = CNT_W'(H_SYNC + H_BACK + H_ACT);
    localparam logic [CNT_W-1:0] Y_START = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] Y_END   = CNT_W'(V_SYNC + V_BACK + V_ACT);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] LEAD    = CNT_W'(REQ_LEAD);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0]   hCont, vCont, hNext, vNext, reqX;
    logic               hEnd, vEnd, activeV, active, reqOn;
    logic [COLOR_W-1:0] pixR, pixG, pixB;

    assign hEnd    = (hCont == H_LAST);
    assign vEnd    = (vCont == V_LAST);
    assign hNext   = hEnd ? '0 : hCont + ONE;
    assign vNext   = vEnd ? '0 : vCont + ONE;
    assign activeV = (vCont >= Y_START) && (vCont < Y_END);
    assign active  = activeV && (hCont >= X_START) && (hCont < X_END);
    assign reqX    = hCont + LEAD;
    assign reqOn   = activeV && (reqX >= X_START) && (reqX < X_END);

    // Raster position
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hCont <= '0;
            vCont <= '0;
        end else begin
            hCont <= hNext;
            if (hEnd) vCont <= vNext;
        end
    end

`ifdef VGA_GRID_OVERLAY_EN
    localparam int unsigned CUR_W   = $clog2(GRID_N);
    localparam int unsigned CELL_CW = CUR_W + 1;
    localparam int unsigned OFF_W   = $clog2(CELL_W);
    localparam logic [CNT_W-1:0]   GX0      = CNT_W'(H_SYNC + H_BACK + GRID_X0);
    localparam logic [CNT_W-1:0]   GX1      = CNT_W'(H_SYNC + H_BACK + GRID_X0 + GRID_N * CELL_W);
    localparam logic [CNT_W-1:0]   GY0      = CNT_W'(V_SYNC + V_BACK + GRID_Y0);
    localparam logic [CNT_W-1:0]   GY1      = CNT_W'(V_SYNC + V_BACK + GRID_Y0 + GRID_N * CELL_W);
    localparam logic [OFF_W-1:0]   OFF_LAST = OFF_W'(CELL_W - 1);
    localparam logic [OFF_W-1:0]   LINE_T   = OFF_W'(LINE_W);
    localparam logic [OFF_W-1:0]   OFF_ONE  = OFF_W'(1);
    localparam logic [CELL_CW-1:0] CELL_ONE = CELL_CW'(1);

    logic [OFF_W-1:0]   hOff, vOff;
    logic [CELL_CW-1:0] hCell, vCell, curX, curY;
    logic               curValid, inGrid, lineCol, lineRow;
    logic               colCur, colNext, rowCur, rowNext, highlight;

    // Cell/offset counters realigned at the grid edges, plus the per-frame cursor latch
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hOff     <= '0;
            hCell    <= '0;
            vOff     <= '0;
            vCell    <= '0;
            curX     <= '0;
            curY     <= '0;
            curValid <= 1'b0;
        end else begin
            if (hNext == GX0) begin
                hOff  <= '0;
                hCell <= '0;
            end else if (hOff == OFF_LAST) begin
                hOff  <= '0;
                hCell <= hCell + CELL_ONE;
            end else begin
                hOff <= hOff + OFF_ONE;
            end
            if (hEnd) begin
                if (vNext == GY0) begin
                    vOff  <= '0;
                    vCell <= '0;
                end else if (vOff == OFF_LAST) begin
                    vOff  <= '0;
                    vCell <= vCell + CELL_ONE;
                end else begin
                    vOff <= vOff + OFF_ONE;
                end
            end
            if ((hCont == '0) && (vCont == '0)) begin
                curX     <= {1'b0, iCur_X};
                curY     <= {1'b0, iCur_Y};
                curValid <= (32'(iCur_X) < GRID_N) && (32'(iCur_Y) < GRID_N);
            end
        end
    end

    assign inGrid  = active && (hCont >= GX0) && (hCont < GX1) && (vCont >= GY0) && (vCont < GY1);
    assign lineCol = (hOff < LINE_T);
    assign lineRow = (vOff < LINE_T);
    assign colCur  = (hCell == curX);
    assign colNext = (hCell == curX + CELL_ONE);
    assign rowCur  = (vCell == curY);
    assign rowNext = (vCell == curY + CELL_ONE);
    // Perimeter of the cursor cell: its left/right column lines and top/bottom row lines
    assign highlight = curValid &&
        ((lineCol && (colCur || colNext) && (rowCur || (rowNext && lineRow))) ||
         (lineRow && (rowCur || rowNext) && (colCur || (colNext && lineCol))));

    always_comb begin
        pixR = '0;
        pixG = '0;
        pixB = '0;
        if (inGrid) begin
            pixR = iRed;
            pixG = iGreen;
            pixB = iBlue;
            if (lineCol || lineRow) begin
                pixR = '1;
                if (highlight) pixG = '1;
            end
        end
    end
`else
    logic unusedGrid;
    assign unusedGrid = ^{iCur_X, iCur_Y, 32'(GRID_N), 32'(CELL_W), 32'(LINE_W),
                          32'(GRID_X0), 32'(GRID_Y0)};

    always_comb begin
        pixR = '0;
        pixG = '0;
        pixB = '0;
        if (active) begin
            pixR = iRed;
            pixG = iGreen;
            pixB = iBlue;
        end
    end
`endif

    assign oVGA_SYNC = 1'b0;

    // Output stage: one cycle behind the raster position
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_H_SYNC  <= 1'b0;
            oVGA_V_SYNC  <= 1'b0;
            oVGA_BLANK   <= 1'b0;
            oRequest     <= 1'b0;
            oH_Cont      <= '0;
            oV_Cont      <= '0;
            oFrame_Start <= 1'b0;
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
        end else begin
            oVGA_H_SYNC  <= (hCont >= HS_END);
            oVGA_V_SYNC  <= (vCont >= VS_END);
            oVGA_BLANK   <= active;
            oRequest     <= reqOn;
            oH_Cont      <= hCont - X_START;
            oV_Cont      <= vCont - Y_START;
            oFrame_Start <= (hCont == '0) && (vCont == '0);
            oVGA_R       <= pixR;
            oVGA_G       <= pixG;
            oVGA_B       <= pixB;
        end
    end
endmodule

// File: tb/tb_vga_grid_controller.sv
// Directed bench for vga_grid_controller on a shortened raster (400 x 38) with a small grid.
// Expected colours follow VGA_GRID_OVERLAY_EN exactly as the design build does.
module tb_vga_grid_controller;
    localparam int HT  = 400;
    localparam int VT  = 38;
    localparam int FT  = HT * VT;
    localparam int XS  = 144;
    localparam int YS  = 5;
    localparam int HA  = 240;
    localparam int VA  = 30;
    localparam int GX0 = 155;
    localparam int GY0 = 4;
    localparam int GN  = 8;
    localparam int CW  = 6;
    localparam int LW  = 2;

    logic        iCLK;
    logic        iRST_N;
    logic [9:0]  iRed, iGreen, iBlue;
    logic [2:0]  iCur_X, iCur_Y;
    logic        oRequest;
    logic [9:0]  oVGA_R, oVGA_G, oVGA_B;
    logic        oVGA_H_SYNC, oVGA_V_SYNC, oVGA_SYNC, oVGA_BLANK;
    logic [12:0] oH_Cont, oV_Cont;
    logic        oFrame_Start;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    vga_grid_controller #(
        .H_SYNC(96), .H_BACK(48), .H_ACT(HA), .H_FRONT(16),
        .V_SYNC(2), .V_BACK(3), .V_ACT(VA), .V_FRONT(3),
        .COLOR_W(10), .GRID_N(GN), .CELL_W(CW), .LINE_W(LW),
        .GRID_X0(GX0), .GRID_Y0(GY0), .REQ_LEAD(2)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iCur_X(iCur_X), .iCur_Y(iCur_Y),
        .oRequest(oRequest),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC),
        .oVGA_SYNC(oVGA_SYNC), .oVGA_BLANK(oVGA_BLANK),
        .oH_Cont(oH_Cont), .oV_Cont(oV_Cont),
        .oFrame_Start(oFrame_Start)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Advance until c rising edges have passed since reset release; outputs then show raster state c-1
    task automatic goto(input int c);
        if (cyc < c) begin
            while (cyc < c) begin
                @(posedge iCLK);
                cyc++;
            end
            #1;
        end
    endtask

    function automatic int pix_cyc(input int frame, input int x, input int y);
        return frame * FT + (YS + y) * HT + XS + x + 1;
    endfunction

    // Reference colour for active coordinate (x,y) with latched cursor (cx,cy)
    function automatic logic [29:0] exp_rgb(input int x, input int y, input int cx, input int cy,
                                            input logic [9:0] r, input logic [9:0] g,
                                            input logic [9:0] b);
`ifdef VGA_GRID_OVERLAY_EN
        int gx, gy, hc, vc;
        logic colL, rowL, hi;
`endif
        if (x < 0 || x >= HA || y < 0 || y >= VA) return '0;
`ifdef VGA_GRID_OVERLAY_EN
        gx = x - GX0;
        gy = y - GY0;
        if (gx < 0 || gx >= GN * CW || gy < 0 || gy >= GN * CW) return '0;
        colL = (gx % CW) < LW;
        rowL = (gy % CW) < LW;
        if (!colL && !rowL) return {r, g, b};
        hc = gx / CW;
        vc = gy / CW;
        hi = (colL && (hc == cx || hc == cx + 1) && (vc == cy || (vc == cy + 1 && rowL))) ||
             (rowL && (vc == cy || vc == cy + 1) && (hc == cx || (hc == cx + 1 && colL)));
        return {10'h3FF, hi ? 10'h3FF : g, b};
`else
        if (cx < 0 || cy < 0) return '0;
        return {r, g, b};
`endif
    endfunction

    task automatic test_reset();
        repeat (4) @(posedge iCLK);
        #1;
        checks++;
        if ({oRequest, oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK,
             oH_Cont, oV_Cont, oFrame_Start} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got R=%h G=%h B=%h hs=%b vs=%b blank=%b req=%b h=%h v=%h fs=%b, required all 0",
                     oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oRequest,
                     oH_Cont, oV_Cont, oFrame_Start);
        end
        checks++;
        if (oVGA_SYNC !== 1'b0) begin
            errors++;
            $display("FAIL vga_sync_const: got %b, required 0", oVGA_SYNC);
        end
        @(negedge iCLK);
        iRST_N = 1'b1;
        cyc = 0;
    endtask

    task automatic test_frame_timing();
        int hsLine0 = 0, hsTotal = 0, vsLow = 0, blanks = 0, reqs = 0, pulses = 0;
        for (int c = 1; c <= FT; c++) begin
            goto(c);
            if (!oVGA_H_SYNC) begin
                hsTotal++;
                if (c - 1 < HT) hsLine0++;
            end
            if (!oVGA_V_SYNC) vsLow++;
            if (oVGA_BLANK) blanks++;
            if (oRequest) reqs++;
            if (oFrame_Start) pulses++;
            if (c == 1) begin
                checks++;
                if (oFrame_Start !== 1'b1 || oH_Cont !== 13'h1F70 || oV_Cont !== 13'h1FFB) begin
                    errors++;
                    $display("FAIL first_state: got fs=%b h=%h v=%h, required fs=1 h=1f70 v=1ffb",
                             oFrame_Start, oH_Cont, oV_Cont);
                end
            end
        end
        checks++;
        if (hsLine0 !== 96) begin
            errors++;
            $display("FAIL hsync_width: got %0d low cycles, required 96", hsLine0);
        end
        checks++;
        if (hsTotal !== 96 * VT) begin
            errors++;
            $display("FAIL hsync_per_frame: got %0d, required %0d", hsTotal, 96 * VT);
        end
        checks++;
        if (vsLow !== 2 * HT) begin
            errors++;
            $display("FAIL vsync_width: got %0d low cycles, required %0d", vsLow, 2 * HT);
        end
        checks++;
        if (blanks !== HA * VA) begin
            errors++;
            $display("FAIL active_count: got %0d, required %0d", blanks, HA * VA);
        end
        checks++;
        if (reqs !== HA * VA) begin
            errors++;
            $display("FAIL request_count: got %0d, required %0d", reqs, HA * VA);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL frame_pulses: got %0d in one frame, required 1", pulses);
        end
        goto(FT + 1);
        checks++;
        if (oFrame_Start !== 1'b1) begin
            errors++;
            $display("FAIL frame_period: got fs=%b at cycle %0d, required 1", oFrame_Start, FT + 1);
        end
    endtask

    task automatic test_request_timing();
        int cs[7]   = '{FT + 4 * HT + 143, FT + 5 * HT + 142, FT + 5 * HT + 143, FT + 5 * HT + 144,
                        FT + 5 * HT + 145, FT + 5 * HT + 382, FT + 5 * HT + 383};
        logic req[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic blk[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            goto(cs[i]);
            checks++;
            if (oRequest !== req[i] || oVGA_BLANK !== blk[i]) begin
                errors++;
                $display("FAIL request_blank[%0d]: got req=%b blank=%b, required req=%b blank=%b",
                         i, oRequest, oVGA_BLANK, req[i], blk[i]);
            end
            if (i == 4) begin
                checks++;
                if (oH_Cont !== 13'd0 || oV_Cont !== 13'd0) begin
                    errors++;
                    $display("FAIL first_pixel_coord: got h=%0d v=%0d, required 0 0", oH_Cont, oV_Cont);
                end
            end
        end
    endtask

    task automatic test_grid_colour();
        int xs[5] = '{10, 155, 160, 155, 167};
        int ys[5] = '{7, 7, 7, 22, 22};
        logic [29:0] exp;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                iCur_X = 3'd2;
                iCur_Y = 3'd3;
            end
            goto(pix_cyc(1, xs[i], ys[i]));
            exp = exp_rgb(xs[i], ys[i], 5, 5, 10'h155, 10'h155, 10'h155);
            checks++;
            if ({oVGA_R, oVGA_G, oVGA_B} !== exp) begin
                errors++;
                $display("FAIL colour(%0d,%0d): got %h/%h/%h, required %h/%h/%h", xs[i], ys[i],
                         oVGA_R, oVGA_G, oVGA_B, exp[29:20], exp[19:10], exp[9:0]);
            end
        end
    endtask

    task automatic test_cursor();
        int xs[7] = '{155, 167, 160, 170, 239, 173, 180};
        int ys[7] = '{22, 22, 23, 25, 25, 28, 29};
        logic [29:0] exp;
        iRed   = 10'h2AA;
        iGreen = 10'h0F0;
        iBlue  = 10'h30C;
        for (int i = 0; i < 7; i++) begin
            goto(pix_cyc(2, xs[i], ys[i]));
            exp = exp_rgb(xs[i], ys[i], 2, 3, 10'h2AA, 10'h0F0, 10'h30C);
            checks++;
            if ({oVGA_R, oVGA_G, oVGA_B} !== exp) begin
                errors++;
                $display("FAIL cursor(%0d,%0d): got %h/%h/%h, required %h/%h/%h", xs[i], ys[i],
                         oVGA_R, oVGA_G, oVGA_B, exp[29:20], exp[19:10], exp[9:0]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        goto(2 * FT + 20 * HT + 200);
        checks++;
        if (oVGA_BLANK !== 1'b1 || oVGA_H_SYNC !== 1'b1 || oVGA_V_SYNC !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got blank=%b hs=%b vs=%b, required 1 1 1",
                     oVGA_BLANK, oVGA_H_SYNC, oVGA_V_SYNC);
        end
        #2 iRST_N = 1'b0;
        #1;
        checks++;
        if ({oRequest, oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK,
             oH_Cont, oV_Cont, oFrame_Start} !== '0) begin
            errors++;
            $display("FAIL async_reset: got R=%h G=%h B=%h hs=%b vs=%b blank=%b req=%b h=%h v=%h, required all 0",
                     oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oRequest,
                     oH_Cont, oV_Cont);
        end
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        iRST_N = 1'b1;
        cyc = 0;
        goto(1);
        checks++;
        if (oFrame_Start !== 1'b1 || oH_Cont !== 13'h1F70 || oV_Cont !== 13'h1FFB) begin
            errors++;
            $display("FAIL restart: got fs=%b h=%h v=%h, required fs=1 h=1f70 v=1ffb",
                     oFrame_Start, oH_Cont, oV_Cont);
        end
        goto(FT);
        checks++;
        if (oFrame_Start !== 1'b0) begin
            errors++;
            $display("FAIL restart_no_early_pulse: got fs=%b, required 0", oFrame_Start);
        end
        goto(FT + 1);
        checks++;
        if (oFrame_Start !== 1'b1) begin
            errors++;
            $display("FAIL restart_full_frame: got fs=%b, required 1", oFrame_Start);
        end
    endtask

    initial begin
        iRST_N = 1'b0;
        iRed   = 10'h155;
        iGreen = 10'h155;
        iBlue  = 10'h155;
        iCur_X = 3'd5;
        iCur_Y = 3'd5;
        test_reset();
        test_frame_timing();
        test_request_timing();
        test_grid_colour();
        test_cursor();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_grid_controller.md
VGA_GRID_CONTROLLER -- requirements
Module: vga_grid_controller

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_SYNC, 96, hsync pulse pixels
- H_BACK, 48, h back porch
- H_ACT, 640, active pixels
- H_FRONT, 16, h front porch
- V_SYNC, 2, vsync lines
- V_BACK, 33, v back porch
- V_ACT, 480, active lines
- V_FRONT, 10, v front porch
- COLOR_W, 10, per-channel colour width
- GRID_N, 8, cells per side
- CELL_W, 60, cell pitch in pixels and lines
- LINE_W, 2, grid-line thickness
- GRID_X0, 155, grid left edge in active coordinates
- GRID_Y0, 46, grid top edge in active coordinates
- REQ_LEAD, 2, cycles oRequest leads pixel display
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- iCLK, in, 1, pixel clock
- iRST_N, in, 1, reset
- iRed/iGreen/iBlue, in, COLOR_W, host pixel
- iCur_X/iCur_Y, in, clog2(GRID_N), cursor cell
- oRequest, out, 1, host pixel request
- oVGA_R/G/B, out, COLOR_W, DAC colour
- oVGA_H_SYNC/oVGA_V_SYNC, out, 1, syncs (active-low)
- oVGA_SYNC, out, 1, constant 0
- oVGA_BLANK, out, 1, 1 = active video
- oH_Cont/oV_Cont, out, 13, active-area coordinate (H_Cont-X_START, mod 2^13)
- oFrame_Start, out, 1, one-cycle frame pulse
REQ-003 Reset iRST_N, asynchronous, active-low; clock iCLK.

Function
REQ-004 H_Cont SHALL count 0..H_TOT-1 (H_TOT = sum of H parameters) and wrap to 0; V_Cont SHALL increment on H wrap and wrap after V_TOT-1.
REQ-005 X_START = H_SYNC+H_BACK and Y_START = V_SYNC+V_BACK; active area SHALL be H_Cont in [X_START, X_START+H_ACT) and V_Cont in [Y_START, Y_START+V_ACT).
REQ-006 Sync SHALL be low while H_Cont<H_SYNC (resp. V_Cont<V_SYNC), and high otherwise.
REQ-007 All VGA outputs SHALL be registered, with exactly 1 cycle of latency from the counter state.
REQ-008 oRequest SHALL be registered and high exactly when (H_Cont+REQ_LEAD) lies in the active columns and V_Cont lies in the active lines.
REQ-009 Grid region SHALL be active x in [GRID_X0, GRID_X0+GRID_N*CELL_W) and active y likewise from GRID_Y0; outside the grid region or the active area, colour SHALL be 0.
REQ-010 A grid-line pixel is one where (x-GRID_X0) mod CELL_W < LINE_W or (y-GRID_Y0) mod CELL_W < LINE_W; on it, R SHALL be all-ones, and G and B SHALL pass through.
REQ-011 Cursor highlight: a grid-line pixel bounding cell (curX, curY) SHALL drive G all-ones as well.
REQ-012 The cursor SHALL be sampled only at H_Cont==0 and V_Cont==0, and held for the whole frame; a sampled value ≥GRID_N SHALL disable the highlight.
REQ-013 Modulo arithmetic SHALL use per-axis cell/offset counters, not dividers, and SHALL be reset at the grid edges.
REQ-014 oFrame_Start SHALL pulse for 1 cycle, registered, for the counter state H_Cont==0 and V_Cont==0.
REQ-015 Parameters with GRID_X0+GRID_N*CELL_W > H_ACT SHALL clip at the active edge without wrap artefacts.

Reset
REQ-016 While iRST_N=0: counters, colour outputs, syncs, oVGA_BLANK, oRequest, oFrame_Start and the cursor latch SHALL be 0.
REQ-017 After deassertion, counting SHALL restart from H_Cont=0, V_Cont=0; a reset mid-frame SHALL abort that frame.

Configuration
REQ-018 With VGA_GRID_OVERLAY_EN defined, REQ-009..REQ-013 SHALL apply.
REQ-019 Without VGA_GRID_OVERLAY_EN, colour SHALL be the host pixel inside the whole active area and 0 elsewhere, with no cursor logic or grid counters synthesised.

Verification
REQ-020 Defaults, one full frame → 800 cycles per line, 525 lines per frame, hsync low 96 cycles, vsync low 2 lines, one oFrame_Start per 420000 cycles.
REQ-021 Host colour 0x155 on all channels, defaults → at x=155,y=100 R=0x3FF, G=0x155; at x=160,y=100 R=G=B=0x155; at x=10 all channels 0.
REQ-022 Cursor (2,3) → at x=275,y=226 G=0x3FF; cursor changed mid-frame → no change until the next oFrame_Start.
REQ-023 oRequest → rises at H_Cont=142 (registered, visible at 143), and displayed pixel 0 appears at output cycle H_Cont=144+1.
REQ-024 iRST_N pulsed low at V_Cont=200 → all outputs 0 asynchronously; after release, H_Cont restarts at 0 and a full frame follows.
REQ-025 Build without VGA_GRID_OVERLAY_EN, host 0x2AA → active pixels all 0x2AA with no grid lines.
